// File: rtl/osd_stm_mc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// osd_stm_mc : multi-channel software-trace capture, round-robin into event FIFO
// Revision   : 1.0
// ============================================================================
module osd_stm_mc #(
  parameter int XLEN     = 64,
  parameter int NCH      = 4,
  parameter int DEPTH    = 16,
  parameter int TS_WIDTH = 32,
  localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [NCH-1:0]        ch_enable,
  input  logic [NCH-1:0]        trace_valid,
  input  logic [NCH*16-1:0]     trace_id,
  input  logic [NCH*XLEN-1:0]   trace_value,
  output logic                  ev_valid,
  input  logic                  ev_ready,
  output logic [CHW-1:0]        ev_channel,
  output logic [TS_WIDTH-1:0]   ev_timestamp,
  output logic [15:0]           ev_id,
  output logic [XLEN-1:0]       ev_value,
  output logic [15:0]           ev_lost,
  output logic [AW:0]           fifo_fill
);

  logic [TS_WIDTH-1:0] ts_cnt;

  logic [NCH-1:0]      slot_full;
  logic [TS_WIDTH-1:0] slot_ts   [NCH];
  logic [15:0]         slot_id   [NCH];
  logic [XLEN-1:0]     slot_val  [NCH];
  logic [15:0]         slot_lost [NCH];
  logic [15:0]         lost_cnt  [NCH];

  logic [NCH-1:0]      cap;
  logic [NCH-1:0]      leave;
  logic [NCH-1:0]      load;

  logic [CHW-1:0]      rr_ptr;
  logic [CHW-1:0]      gnt_idx;
  logic [CHW-1:0]      rr_next;
  logic                gnt;
  logic                pop;
  logic                push_ok;

  logic [CHW-1:0]      mem_ch   [DEPTH];
  logic [TS_WIDTH-1:0] mem_ts   [DEPTH];
  logic [15:0]         mem_id   [DEPTH];
  logic [XLEN-1:0]     mem_val  [DEPTH];
  logic [15:0]         mem_lost [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [AW:0]         fill_q;

  assign ev_valid = (fill_q != '0);
  assign pop      = ev_valid & ev_ready;
  assign push_ok  = (fill_q < (AW+1)'(DEPTH)) | pop;

  // A slot being granted this cycle can accept a new capture in the same cycle.
  generate
    for (genvar c = 0; c < NCH; c++) begin : g_ch
      assign cap[c]   = trace_valid[c] & ch_enable[c] & enable;
      assign leave[c] = gnt & (gnt_idx == CHW'(c));
      assign load[c]  = cap[c] & (~slot_full[c] | leave[c]);
    end
  endgenerate

  // Scan downward so the lowest offset from rr_ptr wins the final assignment.
  always_comb begin
    logic [CHW:0] sum;
    logic [CHW-1:0] idx;
    sum     = '0;
    idx     = '0;
    gnt     = 1'b0;
    gnt_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      sum = {1'b0, rr_ptr} + (CHW+1)'(i);
      if (sum >= (CHW+1)'(NCH)) begin
        sum = sum - (CHW+1)'(NCH);
      end
      idx = sum[CHW-1:0];
      if (push_ok && slot_full[idx]) begin
        gnt     = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  always_comb begin
    rr_next = rr_ptr;
    if (gnt) begin
      rr_next = (gnt_idx == CHW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts_cnt <= '0;
      rr_ptr <= '0;
      for (int c = 0; c < NCH; c++) begin
        slot_full[c] <= 1'b0;
        slot_ts[c]   <= '0;
        slot_id[c]   <= '0;
        slot_val[c]  <= '0;
        slot_lost[c] <= '0;
        lost_cnt[c]  <= '0;
      end
    end else begin
      ts_cnt <= ts_cnt + 1'b1;
      rr_ptr <= rr_next;
      for (int c = 0; c < NCH; c++) begin
        if (load[c]) begin
          slot_full[c] <= 1'b1;
          slot_ts[c]   <= ts_cnt;
          slot_id[c]   <= trace_id[16*c +: 16];
          slot_val[c]  <= trace_value[XLEN*c +: XLEN];
          slot_lost[c] <= lost_cnt[c];
          lost_cnt[c]  <= '0;
        end else begin
          if (leave[c]) begin
            slot_full[c] <= 1'b0;
          end
          if (cap[c] && (lost_cnt[c] != 16'hFFFF)) begin
            lost_cnt[c] <= lost_cnt[c] + 16'd1;
          end
        end
      end
    end
  end

  // Storage needs no reset: head fields are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (gnt) begin
      mem_ch[wr_ptr]   <= gnt_idx;
      mem_ts[wr_ptr]   <= slot_ts[gnt_idx];
      mem_id[wr_ptr]   <= slot_id[gnt_idx];
      mem_val[wr_ptr]  <= slot_val[gnt_idx];
      mem_lost[wr_ptr] <= slot_lost[gnt_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill_q <= '0;
    end else begin
      if (gnt) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({gnt, pop})
        2'b10:   fill_q <= fill_q + 1'b1;
        2'b01:   fill_q <= fill_q - 1'b1;
        default: fill_q <= fill_q;
      endcase
    end
  end

  assign ev_channel   = ev_valid ? mem_ch[rd_ptr]   : '0;
  assign ev_timestamp = ev_valid ? mem_ts[rd_ptr]   : '0;
  assign ev_id        = ev_valid ? mem_id[rd_ptr]   : '0;
  assign ev_value     = ev_valid ? mem_val[rd_ptr]  : '0;
  assign ev_lost      = ev_valid ? mem_lost[rd_ptr] : '0;
  assign fifo_fill    = fill_q;

endmodule
`default_nettype wire
